// File: rtl/plic_prio.sv
// Priority interrupt controller with claim/complete, memory-mapped on the shared strobe/fc bus.
// Optional edge-triggered sources are compiled in when PLIC_EDGE_EN is defined.
module plic_prio #(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int          NUM_SRC    = 15,
  parameter int          PRIO_BITS  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irqs,
  output logic               has_req,
  input  logic [31:0]        addr_bus,
  inout  wire  [31:0]        data_bus,
  input  logic               rd_bus,
  input  logic               wr_bus,
  input  logic [3:0]         data_mask_bus,
  output wire                fc_bus
);

  typedef enum logic {S_IDLE, S_ACK} state_e;

  // Bit 0 (non-existent source 0) is forced to zero in every register.
  localparam logic [31:0] SRC_MASK = 32'(((64'd1 << NUM_SRC) - 64'd1) << 1);

  state_e               state_q, state_d;
  logic [31:0]          pending_q, pending_d, enable_q, enable_d;
  logic [31:0]          inservice_q, inservice_d, rdata_q, rdata_d;
  logic [PRIO_BITS-1:0] thr_q, thr_d;
  logic [PRIO_BITS-1:0] prio_q [1:NUM_SRC];
  logic [PRIO_BITS-1:0] prio_d [1:NUM_SRC];
`ifdef PLIC_EDGE_EN
  logic [31:0]          edge_q, edge_d, prev_q;
`endif

  logic                 strobe, hit, first, do_wr, do_rd, fc_en, dat_en;
  logic [3:0]           woff, mask_sh;
  logic [1:0]           boff;
  logic [31:0]          wdata_sh, bm, wval, rd_word, irq_w, claim_set, set_v, clr_v;
  logic [31:0]          thr_word, pw;
  logic [31:0]          prio_words [4];
  logic [4:0]           best_id, cid;
  logic [PRIO_BITS-1:0] best_prio;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] bmask);
    return (old_v & ~bmask) | (new_v & bmask);
  endfunction

  assign strobe   = rd_bus | wr_bus;
  assign hit      = (addr_bus[31:6] == START_ADDR[31:6]);
  assign woff     = addr_bus[5:2];
  assign boff     = addr_bus[1:0];
  assign first    = (state_q == S_IDLE) && strobe && hit;
  assign do_wr    = first && wr_bus;
  assign do_rd    = first && rd_bus && !wr_bus;
  assign irq_w    = 32'({irqs, 1'b0});
  assign wdata_sh = data_bus << {boff, 3'b000};
  assign mask_sh  = data_mask_bus << boff;

  // Arbitration: ascending scan with >= lets the higher ID win a priority tie.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (pending_q[k] && enable_q[k] && !inservice_q[k] &&
          prio_q[k] > thr_q && prio_q[k] >= best_prio) begin
        best_id   = 5'(k);
        best_prio = prio_q[k];
      end
    end
  end

  assign has_req = (best_id != 5'd0);

  always_comb begin
    for (int w = 0; w < 4; w++) prio_words[w] = '0;
    for (int k = 1; k <= NUM_SRC; k++) prio_words[k/8][4*(k%8) +: PRIO_BITS] = prio_q[k];
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{mask_sh[i]}};
  end

  always_comb begin
    case (woff)
      4'h0:                      rd_word = pending_q;
      4'h1:                      rd_word = enable_q;
      4'h2:                      rd_word = 32'(thr_q);
      4'h3:                      rd_word = 32'(best_id);
`ifdef PLIC_EDGE_EN
      4'h4:                      rd_word = edge_q;
`endif
      4'h5:                      rd_word = inservice_q;
      4'h8, 4'h9, 4'hA, 4'hB:    rd_word = prio_words[woff[1:0]];
      default:                   rd_word = '0;
    endcase
  end

  // NOTE: every signal gets a default at the top of an always_comb so no path infers a latch.
  always_comb begin
    pending_d   = pending_q;
    enable_d    = enable_q;
    inservice_d = inservice_q;
    thr_d       = thr_q;
    prio_d      = prio_q;
    rdata_d     = rdata_q;
`ifdef PLIC_EDGE_EN
    edge_d      = edge_q;
`endif
    claim_set   = '0;
    clr_v       = '0;
    thr_word    = '0;
    pw          = '0;
    wval        = wdata_sh & bm;
    cid         = wval[4:0];

    if (do_rd) rdata_d = rd_word >> {boff, 3'b000};
    if (do_rd && woff == 4'h3 && best_id != 5'd0) claim_set[best_id] = 1'b1;

    if (do_wr) begin
      case (woff)
        4'h0: clr_v = wval;
        4'h1: enable_d = merge(enable_q, wdata_sh, bm) & SRC_MASK;
        4'h2: begin
          thr_word = merge(32'(thr_q), wdata_sh, bm);
          thr_d    = thr_word[PRIO_BITS-1:0];
        end
        4'h3: if (cid != 5'd0 && int'(cid) <= NUM_SRC) inservice_d[cid] = 1'b0;
`ifdef PLIC_EDGE_EN
        4'h4: edge_d = merge(edge_q, wdata_sh, bm) & SRC_MASK;
`endif
        4'h8, 4'h9, 4'hA, 4'hB: begin
          for (int k = 1; k <= NUM_SRC; k++) begin
            if (woff[1:0] == 2'(k/8)) begin
              pw        = merge(prio_words[k/8], wdata_sh, bm);
              prio_d[k] = pw[4*(k%8) +: PRIO_BITS];
            end
          end
        end
        default: ;
      endcase
    end

    inservice_d = (inservice_d | claim_set) & SRC_MASK;
    clr_v       = clr_v | claim_set;
    // A level source being claimed this cycle counts as in service, so it cannot re-pend.
`ifdef PLIC_EDGE_EN
    set_v = ((irq_w & ~prev_q & edge_q) |
             (irq_w & ~edge_q & ~(inservice_q | claim_set))) & SRC_MASK;
`else
    set_v = irq_w & ~(inservice_q | claim_set) & SRC_MASK;
`endif
    pending_d = ((pending_q & ~clr_v) | set_v) & SRC_MASK;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the priority array is a handful of flops, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      enable_q    <= '0;
      inservice_q <= '0;
      thr_q       <= '0;
      rdata_q     <= '0;
      for (int k = 1; k <= NUM_SRC; k++) prio_q[k] <= '0;
`ifdef PLIC_EDGE_EN
      edge_q      <= '0;
      prev_q      <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      inservice_q <= inservice_d;
      thr_q       <= thr_d;
      rdata_q     <= rdata_d;
      prio_q      <= prio_d;
`ifdef PLIC_EDGE_EN
      edge_q      <= edge_d;
      prev_q      <= irq_w;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (first)   state_d = S_ACK;
      S_ACK:   if (!strobe) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fc_en  = (state_q == S_ACK);
    dat_en = (state_q == S_ACK) && rd_bus;
  end

  assign fc_bus   = fc_en  ? strobe  : 1'bz;
  assign data_bus = dat_en ? rdata_q : 32'bz;

endmodule

// File: tb/tb_plic_prio.sv
// Directed self-checking bench for plic_prio (default parameters: 15 sources, 3-bit priority).
module tb_plic_prio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] irqs;
  logic        has_req;
  logic [31:0] addr_bus;
  logic [31:0] tb_data;
  logic        tb_drv;
  logic        rd_bus, wr_bus;
  logic [3:0]  data_mask_bus;
  wire  [31:0] data_bus;
  wire         fc_bus;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rv;

  assign data_bus = tb_drv ? tb_data : 32'bz;

  always #5 clk = ~clk;

  plic_prio dut (
    .clk(clk), .rst_n(rst_n), .irqs(irqs), .has_req(has_req),
    .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    addr_bus = a; tb_data = d; tb_drv = 1'b1; data_mask_bus = m; wr_bus = 1'b1;
    @(posedge clk); #1;
    check("fc_wr", 32'(fc_bus), 32'd1);
    @(negedge clk);
    wr_bus = 1'b0; tb_drv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_bus = a; rd_bus = 1'b1;
    @(posedge clk); #1;
    check("fc_rd", 32'(fc_bus), 32'd1);
    d = data_bus;
    @(negedge clk);
    rd_bus = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] offs [10];
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h24, 32'h28, 32'h2C};
    rst_n = 1'b0; irqs = '0; addr_bus = '0; tb_data = '0; tb_drv = 1'b0;
    rd_bus = 1'b0; wr_bus = 1'b0; data_mask_bus = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("reset_has_req", 32'(has_req), 32'd0);
    for (int i = 0; i < 10; i++) rd_chk("reset_reg", offs[i], 32'h0);

    // Two equal-priority sources: higher ID claimed first
    bus_wr(32'h20, 32'h0020_2000, 4'hF);
    rd_chk("prio_word0", 32'h20, 32'h0020_2000);
    bus_wr(32'h04, 32'h28, 4'hF);
    bus_wr(32'h08, 32'h1, 4'hF);
    @(negedge clk); irqs = 15'h0014;
    @(negedge clk); irqs = '0;
    @(posedge clk); #1;
    check("t2_has_req", 32'(has_req), 32'd1);
    rd_chk("t2_pending", 32'h00, 32'h28);
    rd_chk("t2_claim5", 32'h0C, 32'd5);
    rd_chk("t2_inservice", 32'h14, 32'h20);
    rd_chk("t2_claim3", 32'h0C, 32'd3);
    check("t2_no_req", 32'(has_req), 32'd0);
    rd_chk("t2_claim_none", 32'h0C, 32'd0);
    bus_wr(32'h0C, 32'd5, 4'hF);
    bus_wr(32'h0C, 32'd3, 4'hF);
    rd_chk("t2_inservice_clr", 32'h14, 32'h0);

    // Threshold equal to priority masks the source
    bus_wr(32'h20, 32'h1020_2000, 4'hF);
    bus_wr(32'h04, 32'h80, 4'hF);
    @(negedge clk); irqs = 15'h0040;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_masked", 32'(has_req), 32'd0);
    bus_wr(32'h08, 32'h0, 4'hF);
    check("t3_unmasked", 32'(has_req), 32'd1);
    rd_chk("t3_claim7", 32'h0C, 32'd7);
    @(negedge clk); irqs = '0;
    bus_wr(32'h0C, 32'd7, 4'hF);
    rd_chk("t3_pending", 32'h00, 32'h0);

    // Held level source does not re-pend until completed
    bus_wr(32'h20, 32'h1020_2300, 4'hF);
    bus_wr(32'h04, 32'h04, 4'hF);
    @(negedge clk); irqs = 15'h0002;
    @(posedge clk); #1;
    rd_chk("t4_claim2", 32'h0C, 32'd2);
    rd_chk("t4_pend_held", 32'h00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd_chk("t4_pend_still", 32'h00, 32'h0);
    bus_wr(32'h0C, 32'd2, 4'hF);
    rd_chk("t4_pend_reset", 32'h00, 32'h04);
    check("t4_has_req", 32'(has_req), 32'd1);
    rd_chk("t4_claim2b", 32'h0C, 32'd2);
    @(negedge clk); irqs = '0;

    // Byte-lane write, tied bit 0, out-of-range completes
    bus_wr(32'h04, 32'h0, 4'hF);
    bus_wr(32'h05, 32'h0000_00FF, 4'h1);
    rd_chk("t6_enable_byte", 32'h04, 32'h0000_FF00);
    bus_wr(32'h04, 32'h0000_0001, 4'h1);
    rd_chk("t6_enable_bit0", 32'h04, 32'h0000_FF00);
    bus_wr(32'h0C, 32'd0, 4'hF);
    bus_wr(32'h0C, 32'd31, 4'hF);
    rd_chk("t6_inservice_kept", 32'h14, 32'h04);
    bus_wr(32'h0C, 32'd2, 4'hF);
    rd_chk("t6_inservice_clr", 32'h14, 32'h0);

    // W1C on pending and unmapped offsets
    @(negedge clk); irqs = 15'h0100;
    @(negedge clk); irqs = '0;
    rd_chk("w1c_before", 32'h00, 32'h200);
    bus_wr(32'h00, 32'h200, 4'hF);
    rd_chk("w1c_after", 32'h00, 32'h0);
    bus_wr(32'h30, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped", 32'h30, 32'h0);

`ifdef PLIC_EDGE_EN
    // Edge source re-pends while in service
    bus_wr(32'h10, 32'h10, 4'hF);
    rd_chk("t5_edge_reg", 32'h10, 32'h10);
    bus_wr(32'h20, 32'h1022_2300, 4'hF);
    bus_wr(32'h04, 32'h10, 4'hF);
    @(negedge clk); irqs = 15'h0008;
    @(posedge clk); #1;
    rd_chk("t5_claim4", 32'h0C, 32'd4);
    @(negedge clk); irqs = '0;
    @(negedge clk); irqs = 15'h0008;
    @(negedge clk); irqs = '0;
    rd_chk("t5_pending", 32'h00, 32'h10);
    rd_chk("t5_claim_blocked", 32'h0C, 32'd0);
    bus_wr(32'h0C, 32'd4, 4'hF);
    rd_chk("t5_claim4b", 32'h0C, 32'd4);
`else
    bus_wr(32'h10, 32'h10, 4'hF);
    rd_chk("edge_disabled", 32'h10, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
